// File: rtl/dot4_frac_mac.sv
// dot4_frac_mac: four-lane signed fractional dot product with per-lane rounding, saturating adder tree and registered output
module dot4_frac_mac #(
  parameter int WIDTH_A_80         = 9,
  parameter int WIDTH_B_80         = 8,
  parameter int WIDTH_PROD         = WIDTH_A_80 + WIDTH_B_80,
  parameter int WIDTH_PROD_ROUNDED = 9,
  parameter int WIDTH_SUM          = 11
) (
  input  logic                  clk_80,
  input  logic                  rst_80,
  input  logic [WIDTH_A_80-1:0] A00_80,
  input  logic [WIDTH_A_80-1:0] A01_80,
  input  logic [WIDTH_A_80-1:0] A02_80,
  input  logic [WIDTH_A_80-1:0] A03_80,
  input  logic [WIDTH_B_80-1:0] B00_80,
  input  logic [WIDTH_B_80-1:0] B01_80,
  input  logic [WIDTH_B_80-1:0] B02_80,
  input  logic [WIDTH_B_80-1:0] B03_80,
  output logic [WIDTH_SUM-1:0]  AB00_80
);
  localparam logic [WIDTH_A_80-1:0] A_MIN = {1'b1, {(WIDTH_A_80-1){1'b0}}};
  localparam logic [WIDTH_A_80-1:0] A_FIX = {1'b1, {(WIDTH_A_80-2){1'b0}}, 1'b1};
  localparam logic [WIDTH_B_80-1:0] B_MIN = {1'b1, {(WIDTH_B_80-1){1'b0}}};
  localparam logic [WIDTH_B_80-1:0] B_FIX = {1'b1, {(WIDTH_B_80-2){1'b0}}, 1'b1};
  localparam logic [WIDTH_PROD_ROUNDED-1:0] R_MAX = {1'b0, {(WIDTH_PROD_ROUNDED-1){1'b1}}};
  localparam logic [WIDTH_SUM-1:0] S_MAX = {1'b0, {(WIDTH_SUM-1){1'b1}}};
  localparam logic [WIDTH_SUM-1:0] S_MIN = {1'b1, {(WIDTH_SUM-1){1'b0}}};

  logic [WIDTH_A_80-1:0]        w_a [4];
  logic [WIDTH_B_80-1:0]        w_b [4];
  logic signed [WIDTH_SUM-1:0]  w_e [4];
  logic [WIDTH_SUM-1:0]         w_sum;
  logic [WIDTH_SUM-1:0]         r_ab;

  assign w_a = '{A00_80, A01_80, A02_80, A03_80};
  assign w_b = '{B00_80, B01_80, B02_80, B03_80};

  // Two's complement add that clamps to the rail when both operands share a sign the result lost
  function automatic logic [WIDTH_SUM-1:0] sat_add(input logic [WIDTH_SUM-1:0] x, input logic [WIDTH_SUM-1:0] y);
    logic [WIDTH_SUM-1:0] s;
    s = x + y;
    return (x[WIDTH_SUM-1] == y[WIDTH_SUM-1] && s[WIDTH_SUM-1] != x[WIDTH_SUM-1]) ?
           (x[WIDTH_SUM-1] ? S_MIN : S_MAX) : s;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic signed [WIDTH_A_80-1:0]         w_ac;
    logic signed [WIDTH_B_80-1:0]         w_bc;
    logic signed [WIDTH_PROD-1:0]         w_p;
    logic [WIDTH_PROD_ROUNDED-1:0]        w_t;
    logic                                 w_rb;
    logic signed [WIDTH_PROD_ROUNDED-1:0] w_r;
    // -1 is nudged to the most negative legal fraction so the product stays strictly inside (-1,1)
    assign w_ac = (w_a[i] == A_MIN) ? A_FIX : w_a[i];
    assign w_bc = (w_b[i] == B_MIN) ? B_FIX : w_b[i];
    assign w_p  = w_ac * w_bc;
    // The top product bit duplicates the next one, so the rounded field starts one below the MSB
    assign w_t  = w_p[WIDTH_PROD-2 -: WIDTH_PROD_ROUNDED];
    assign w_rb = w_p[WIDTH_PROD-2-WIDTH_PROD_ROUNDED];
    assign w_r  = (w_t == R_MAX && w_rb) ? R_MAX : w_t + WIDTH_PROD_ROUNDED'(w_rb);
    assign w_e[i] = WIDTH_SUM'(w_r);
  end

  // Two-level saturating adder tree over the rounded lane products
  always_comb w_sum = sat_add(sat_add(w_e[0], w_e[1]), sat_add(w_e[2], w_e[3]));

  // Output register with synchronous active-low clear
  always_ff @(posedge clk_80) r_ab <= !rst_80 ? '0 : w_sum;

  assign AB00_80 = r_ab;
endmodule

// File: tb/tb_dot4_frac_mac.sv
// tb_dot4_frac_mac: directed checks of dot4_frac_mac against an integer arithmetic model and hand-computed values
module tb_dot4_frac_mac;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  ta [4];
  logic [7:0]  tb [4];
  logic [10:0] ab11;
  logic [8:0]  ab9;
  int          n_pass = 0;
  int          n_tot = 0;
  bit          valid = 1'b0;
  logic [10:0] e11;
  logic [8:0]  e9;

  always #5 clk = ~clk;

  dot4_frac_mac dut11 (
    .clk_80(clk), .rst_80(rst),
    .A00_80(ta[0]), .A01_80(ta[1]), .A02_80(ta[2]), .A03_80(ta[3]),
    .B00_80(tb[0]), .B01_80(tb[1]), .B02_80(tb[2]), .B03_80(tb[3]),
    .AB00_80(ab11)
  );

  dot4_frac_mac #(.WIDTH_SUM(9)) dut9 (
    .clk_80(clk), .rst_80(rst),
    .A00_80(ta[0]), .A01_80(ta[1]), .A02_80(ta[2]), .A03_80(ta[3]),
    .B00_80(tb[0]), .B01_80(tb[1]), .B02_80(tb[2]), .B03_80(tb[3]),
    .AB00_80(ab9)
  );

  function automatic int lane(input logic [8:0] a, input logic [7:0] b);
    int ia, ib, r;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ia == -256) ia = -255;
    if (ib == -128) ib = -127;
    r = (ia * ib + 64) >>> 7;
    return (r > 255) ? 255 : r;
  endfunction

  function automatic int sat(input int x, input int ws);
    int hi, lo;
    hi = (1 << (ws - 1)) - 1;
    lo = -(1 << (ws - 1));
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  function automatic int model(input int ws);
    int s0, s1;
    s0 = sat(lane(ta[0], tb[0]) + lane(ta[1], tb[1]), ws);
    s1 = sat(lane(ta[2], tb[2]) + lane(ta[3], tb[3]), ws);
    return sat(s0 + s1, ws);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    int m11, m9;
    m11 = rst ? model(11) : 0;
    m9  = rst ? model(9) : 0;
    e11 = m11[10:0];
    e9  = m9[8:0];
    valid = 1'b1;
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("stream11", int'(ab11), int'(e11));
      chk("stream9", int'(ab9), int'(e9));
    end
  end

  task automatic vec(input string name,
                     input logic [8:0] a0, input logic [8:0] a1, input logic [8:0] a2, input logic [8:0] a3,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                     input int lit11, input int lit9);
    @(negedge clk);
    ta = '{a0, a1, a2, a3};
    tb = '{b0, b1, b2, b3};
    @(posedge clk);
    #1;
    if (lit11 >= 0) chk({name, "_11"}, int'(ab11), lit11);
    if (lit9 >= 0) chk({name, "_9"}, int'(ab9), lit9);
  endtask

  initial begin
    ta = '{9'h080, 9'h080, 9'h080, 9'h080};
    tb = '{8'h40, 8'h40, 8'h40, 8'h40};
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset11", int'(ab11), 0);
    chk("reset9", int'(ab9), 0);
    #2;
    ta = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF};
    #1;
    chk("reset_async11", int'(ab11), 0);
    @(posedge clk);
    #1;
    chk("reset_hold11", int'(ab11), 0);
    @(negedge clk);
    ta = '{9'h080, 9'h080, 9'h080, 9'h080};
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("release11", int'(ab11), 'h100);
    chk("release9", int'(ab9), 'h0FF);
    vec("basic", 9'h080, 9'h000, 9'h000, 9'h000, 8'h40, 8'h00, 8'h00, 8'h00, 'h040, 'h040);
    vec("four", 9'h080, 9'h080, 9'h080, 9'h080, 8'h40, 8'h40, 8'h40, 8'h40, 'h100, 'h0FF);
    vec("neg", 9'h180, 9'h000, 9'h000, 9'h000, 8'h40, 8'h00, 8'h00, 8'h00, 'h7C0, 'h1C0);
    vec("round_up", 9'h001, 9'h000, 9'h000, 9'h000, 8'h40, 8'h00, 8'h00, 8'h00, 'h001, 'h001);
    vec("round_dn", 9'h001, 9'h000, 9'h000, 9'h000, 8'h20, 8'h00, 8'h00, 8'h00, 'h000, 'h000);
    vec("illegal4", 9'h100, 9'h100, 9'h100, 9'h100, 8'h80, 8'h80, 8'h80, 8'h80, 'h3F4, 'h0FF);
    vec("illegal1", 9'h100, 9'h000, 9'h000, 9'h000, 8'h80, 8'h00, 8'h00, 8'h00, 'h0FD, 'h0FD);
    vec("sat_pos", 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 'h3F4, 'h0FF);
    vec("sat_neg", 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 8'h81, 8'h81, 8'h81, 8'h81, 'h40C, 'h100);
    vec("mixed", 9'h0FF, 9'h100, 9'h180, 9'h001, 8'h7F, 8'h80, 8'h40, 8'h40, 'h1BB, 'h0C0);
    vec("illegal_b", 9'h080, 9'h000, 9'h000, 9'h000, 8'h80, 8'h00, 8'h00, 8'h00, 'h781, 'h181);
    for (int k = 0; k < 24; k++)
      vec("rand", 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom),
          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
